// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: funct3 load/store
// encodings, result-select encodings, FSM state type and alignment helpers.
package mem_access_unit_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Write-back result select encodings
    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    // Memory stage FSM
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mau_state_e;

    // Access size derived from funct3; the unused encodings 011/110/111
    // fall into the word class so they behave like LW.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_e;

    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // A halfword must sit on an even address, a word on a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (access_size(funct3))
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return |addr_lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// lsu_align: purely combinational byte-lane formatting for a 32-bit bus.
// Produces store byte enables / replicated store data and extracts plus
// extends load data from the lane selected by the low address bits.
module lsu_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_store_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] rdata_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Move the addressed lane down to bit 0 so extraction is lane-independent.
    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign load_byte     = rdata_shifted[7:0];
    assign load_half     = rdata_shifted[15:0];

    // Store formatting: byte enables follow the address, data is replicated
    // across all lanes so the enabled lane always carries the right bits.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be_store_o = 4'b1111;
        wdata_o    = store_data_i;
        case (access_size(funct3_i))
            SZ_BYTE: begin
                be_store_o = 4'(4'b0001 << addr_lo_i);
                wdata_o    = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_store_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{store_data_i[15:0]}};
            end
            default: begin
                be_store_o = 4'b1111;
                wdata_o    = store_data_i;
            end
        endcase
    end

    // Load extension: signed/unsigned byte and halfword, everything else
    // passes the full word through.
    always_comb begin
        load_data_o = rdata_i;
        case (funct3_i)
            F3_LB:   load_data_o = {{24{load_byte[7]}}, load_byte};
            F3_LH:   load_data_o = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_data_o = {24'b0, load_byte};
            F3_LHU:  load_data_o = {16'b0, load_half};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: EX/MEM pipeline register plus the MEM-stage data bus
// master. Aligned loads/stores run a request on the data bus and stall the
// pipe until the slave answers; misaligned ops are dropped and flagged.
// The byte-lane path assumes a 32-bit data bus (DATA_WIDTH = 32).
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int DATA_ADDR_WIDTH     = 32,
    parameter int REGISTER_ADDR_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // EX stage
    input  logic                           reg_write_EX,
    input  logic                           mem_write_EX,
    input  logic [1:0]                     result_sel_EX,
    input  logic [DATA_WIDTH-1:0]          alu_res_EX,
    input  logic [DATA_WIDTH-1:0]          write_data_EX,
    input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
    input  logic [2:0]                     funct3_EX,
    input  logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_EX,
    input  logic                           flush_EX_MEM,
    // EX/MEM register (also the forwarding source)
    output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
    output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
    output logic                           reg_write_EX_MEM_o,
    output logic [1:0]                     result_sel_EX_MEM_o,
    output logic [DATA_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o,
    // MEM stage status
    output logic [DATA_WIDTH-1:0]          load_data_MEM,
    output logic                           mem_done_MEM,
    output logic                           stall_MEM,
    output logic                           misalign_MEM,
    // Data bus
    output logic                           dmem_req,
    output logic                           dmem_we,
    output logic [DATA_ADDR_WIDTH-1:0]     dmem_addr,
    output logic [DATA_WIDTH-1:0]          dmem_wdata,
    output logic [3:0]                     dmem_be,
    input  logic                           dmem_ready,
    input  logic [DATA_WIDTH-1:0]          dmem_rdata
);

    mau_state_e                     state_q, state_d;

    logic [DATA_WIDTH-1:0]          alu_res_q, alu_res_d;
    logic [DATA_WIDTH-1:0]          write_data_q, write_data_d;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                           reg_write_q, reg_write_d;
    logic                           mem_write_q, mem_write_d;
    logic [1:0]                     result_sel_q, result_sel_d;
    logic [2:0]                     funct3_q, funct3_d;
    logic [DATA_ADDR_WIDTH-1:0]     pc_plus_4_q, pc_plus_4_d;
    logic                           misalign_q, misalign_d;

    logic                           mem_op_EX;
    logic                           misaligned_EX;
    logic                           start_access;
    logic [DATA_ADDR_WIDTH-1:0]     mem_addr;
    logic [3:0]                     be_store;

    // Classify the incoming instruction; only an aligned, unflushed memory
    // op launches a bus access.
    assign mem_op_EX     = mem_write_EX || (result_sel_EX == RES_LOAD);
    assign misaligned_EX = mem_op_EX && is_misaligned(funct3_EX, alu_res_EX[1:0]);
    assign start_access  = mem_op_EX && !misaligned_EX && !flush_EX_MEM;

    // EX/MEM next-state: hold while stalled, else capture EX or a bubble.
    always_comb begin
        alu_res_d    = alu_res_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_sel_d = result_sel_q;
        funct3_d     = funct3_q;
        pc_plus_4_d  = pc_plus_4_q;
        misalign_d   = misalign_q;
        if (!stall_MEM) begin
            alu_res_d    = alu_res_EX;
            write_data_d = write_data_EX;
            rd_d         = rd_EX;
            funct3_d     = funct3_EX;
            pc_plus_4_d  = PC_plus_4_EX;
            if (flush_EX_MEM) begin
                reg_write_d  = 1'b0;
                mem_write_d  = 1'b0;
                result_sel_d = RES_ALU;
                misalign_d   = 1'b0;
            end else begin
                // A misaligned op must never write back its (bogus) result.
                misalign_d   = misaligned_EX;
                reg_write_d  = reg_write_EX && !misaligned_EX;
                mem_write_d  = mem_write_EX;
                result_sel_d = result_sel_EX;
            end
        end
    end

    // FSM next state: stay in ACCESS until the slave answers; otherwise the
    // instruction being captured decides, giving back-to-back accesses.
    always_comb begin
        state_d = state_q;
        if (!stall_MEM) begin
            state_d = start_access ? ST_ACCESS : ST_IDLE;
        end
    end

    // State and EX/MEM register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only, so all
            // registers update together from pre-edge values.
            state_q      <= ST_IDLE;
            alu_res_q    <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_sel_q <= '0;
            funct3_q     <= '0;
            pc_plus_4_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_res_q    <= alu_res_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_sel_q <= result_sel_d;
            funct3_q     <= funct3_d;
            pc_plus_4_q  <= pc_plus_4_d;
            misalign_q   <= misalign_d;
        end
    end

    // Word-aligned bus address from the registered effective address.
    assign mem_addr  = DATA_ADDR_WIDTH'(alu_res_q);
    assign dmem_addr = {mem_addr[DATA_ADDR_WIDTH-1:2], 2'b00};

    lsu_align u_lsu_align (
        .funct3_i     (funct3_q),
        .addr_lo_i    (alu_res_q[1:0]),
        .store_data_i (write_data_q),
        .rdata_i      (dmem_rdata),
        .be_store_o   (be_store),
        .wdata_o      (dmem_wdata),
        .load_data_o  (load_data_MEM)
    );

    // Bus handshake and stage status; dmem_ready only matters in ACCESS.
    always_comb begin
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_be      = 4'b0000;
        stall_MEM    = 1'b0;
        mem_done_MEM = 1'b0;
        if (state_q == ST_ACCESS) begin
            dmem_req     = 1'b1;
            dmem_we      = mem_write_q;
            dmem_be      = mem_write_q ? be_store : 4'b1111;
            stall_MEM    = !dmem_ready;
            mem_done_MEM = dmem_ready;
        end
    end

    assign alu_res_EX_MEM_o    = alu_res_q;
    assign rd_EX_MEM_o         = rd_q;
    assign reg_write_EX_MEM_o  = reg_write_q;
    assign result_sel_EX_MEM_o = result_sel_q;
    assign PC_plus_4_EX_MEM_o  = pc_plus_4_q;
    assign misalign_MEM        = misalign_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, as the data path width.
REQ-002 The block SHALL have parameter DATA_ADDR_WIDTH, default 32, as the data address width.
REQ-003 The block SHALL have parameter REGISTER_ADDR_WIDTH, default 5, as the register index width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-006 The block SHALL have port reg_write_EX, input, 1, the EX register-write enable.
REQ-007 The block SHALL have port mem_write_EX, input, 1, the EX store request.
REQ-008 The block SHALL have port result_sel_EX, input, 2, the result select; 2'b01 means load.
REQ-009 The block SHALL have ports alu_res_EX and write_data_EX, input, DATA_WIDTH: the effective address / ALU result, and the forwarded store data.
REQ-010 The block SHALL have ports rd_EX (REGISTER_ADDR_WIDTH), funct3_EX (3) and PC_plus_4_EX (DATA_ADDR_WIDTH), all inputs.
REQ-011 The block SHALL have port flush_EX_MEM, input, 1, which inserts a bubble.
REQ-012 The block SHALL have outputs alu_res_EX_MEM_o (DATA_WIDTH), rd_EX_MEM_o, reg_write_EX_MEM_o, result_sel_EX_MEM_o and PC_plus_4_EX_MEM_o: the registered EX/MEM fields, also used as the forwarding source.
REQ-013 The block SHALL have output load_data_MEM, DATA_WIDTH: the load data, extended per funct3.
REQ-014 The block SHALL have outputs mem_done_MEM (1), stall_MEM (1) and misalign_MEM (1).
REQ-015 The block SHALL have data-bus outputs dmem_req (1), dmem_we (1), dmem_addr (DATA_ADDR_WIDTH), dmem_wdata (DATA_WIDTH) and dmem_be (4).
REQ-016 The block SHALL have data-bus inputs dmem_ready (1) and dmem_rdata (DATA_WIDTH).

Function
REQ-017 The EX/MEM register SHALL capture all EX inputs on each rising edge where stall_MEM=0. It SHALL hold while stall_MEM=1, even if flush_EX_MEM=1.
REQ-018 With stall_MEM=0 and flush_EX_MEM=1, the register SHALL load a bubble: all controls 0, data fields don't-care.
REQ-019 The FSM SHALL have states IDLE and ACCESS. A captured memory op (mem_write=1 or result_sel=2'b01) that is aligned SHALL enter ACCESS. Otherwise the FSM SHALL enter IDLE.
REQ-020 In ACCESS, the block SHALL drive dmem_req=1, with dmem_addr = {alu_res[31:2],2'b00} and dmem_we = the registered mem_write. These SHALL stay stable until dmem_ready=1.
REQ-021 stall_MEM SHALL equal (state==ACCESS && !dmem_ready), combinationally.
REQ-022 In ACCESS with dmem_ready=1, the block SHALL pulse mem_done_MEM=1 for that cycle. load_data_MEM SHALL be valid in that cycle. The next state SHALL be set by the newly captured instruction, allowing back-to-back accesses with no idle cycle.
REQ-023 Store byte enables and data SHALL be:
- SB (funct3 000): dmem_be = 1<<addr[1:0], byte replicated to all lanes.
- SH (funct3 001): dmem_be = addr[1] ? 4'b1100 : 4'b0011, halfword replicated.
- SW (funct3 010): dmem_be = 4'b1111.
REQ-024 Loads SHALL select the byte lane by addr[1:0] and extend as follows: LB sign-extend, LH sign-extend, LW pass-through, LBU zero-extend, LHU zero-extend. funct3 011, 110 and 111 SHALL be treated as LW.
REQ-025 For loads, dmem_be SHALL be 4'b1111.
REQ-026 Misalignment is a halfword op with addr[0]=1, or a word op with addr[1:0]!=0. On a misaligned op the block SHALL:
- issue no request;
- assert misalign_MEM for one cycle;
- force reg_write_EX_MEM_o=0 for that instruction.
REQ-027 A non-memory instruction SHALL pass through in one cycle, with dmem_req=0 and mem_done_MEM=0.
REQ-028 dmem_ready SHALL be ignored while the FSM is in IDLE.

Reset
REQ-029 When rst_n=0, asynchronously: the FSM SHALL go to IDLE; all EX/MEM fields SHALL be 0; dmem_req, dmem_we, stall_MEM, mem_done_MEM and misalign_MEM SHALL be 0.
REQ-030 Reset asserted during ACCESS SHALL abandon the access. After release, the block SHALL resume in IDLE, with no request re-issued.

Structure
REQ-031 A shared package SHALL hold the funct3 load/store constants, the result_sel encodings and the FSM state type.
REQ-032 Byte-lane formatting (be/wdata generation, load extraction and extension) SHALL be a combinational sub-module named lsu_align.

Verification
REQ-033 SW test: addr=0x100, data=0xDEADBEEF, dmem_ready tied 1. Required: one-cycle req with we=1, be=1111, wdata=0xDEADBEEF, stall_MEM never 1.
REQ-034 LB test: addr=0x103, rdata=0x80112233, 3 wait cycles. Required: stall_MEM=1 for exactly 3 cycles, then load_data_MEM=0xFFFFFF80 with mem_done_MEM=1.
REQ-035 SH test: addr=0x102, data=0x0000ABCD. Required: be=1100, wdata=0xABCDABCD.
REQ-036 LW misaligned test: addr=0x101. Required: misalign_MEM=1, dmem_req=0, reg_write_EX_MEM_o=0.
REQ-037 Back-to-back LW then SW, ready=1. Required: req asserted two consecutive cycles. Also, flush_EX_MEM=1 during a stall leaves the held fields unchanged.
REQ-038 Reset test: assert rst_n=0 mid-ACCESS. Required: dmem_req=0 immediately, state IDLE after release.
